// File: rtl/cnn_avgp_pkg.sv
// Shared types, default geometry and width helper for the 3x3 average-pool sequencer.
package cnn_avgp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } avgp_ctrl_state_t;

  localparam int DEF_DATA_WIDTH     = 32;
  localparam int DEF_IMAGE_WIDTH    = 16;
  localparam int DEF_IMAGE_HEIGHT   = 16;
  localparam int DEF_CHANNEL_NUM_IN = 4;

  localparam int IMAGE_SIZE = DEF_IMAGE_WIDTH * DEF_IMAGE_HEIGHT;
  localparam int TOTAL_IN   = DEF_CHANNEL_NUM_IN * IMAGE_SIZE;
  localparam int TOTAL_OUT  = DEF_CHANNEL_NUM_IN * IMAGE_SIZE;
  localparam int AW         = $clog2(TOTAL_IN);
  localparam int OW         = $clog2(TOTAL_OUT);

  // Index width for n distinct values, never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cnn_frame_counter.sv
// Saturating pixel counter with a per-group (channel) index and a terminal-count flag.
module cnn_frame_counter
  import cnn_avgp_pkg::*;
#(
  parameter int MAX_COUNT = 1023,
  parameter int TC_VALUE  = 1023,
  parameter int GROUP     = 256,
  parameter int GROUPS    = 4,
  localparam int CW = $clog2(MAX_COUNT + 1),
  localparam int PW = idx_width(GROUP),
  localparam int GW = idx_width(GROUPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          inc,
  output logic [CW-1:0] count,
  output logic [GW-1:0] group,
  output logic          tc
);

  logic [PW-1:0] pix;

  // Count advances until MAX_COUNT; group index saturates at the last group.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      pix   <= '0;
      group <= '0;
    end else if (clear) begin
      count <= '0;
      pix   <= '0;
      group <= '0;
    end else if (inc && (count != CW'(MAX_COUNT))) begin
      count <= count + 1'b1;
      if (pix == PW'(GROUP - 1)) begin
        pix <= '0;
        if (group != GW'(GROUPS - 1)) begin
          group <= group + 1'b1;
        end
      end else begin
        pix <= pix + 1'b1;
      end
    end
  end

  assign tc = (count == CW'(TC_VALUE));

endmodule

// File: rtl/cnn_avgp_3x3_ctrl.sv
// Run sequencer for the 3x3 average pool: streams the input buffer into the pool,
// collects pool outputs into the output buffer, and guards the drain with a watchdog.
module cnn_avgp_3x3_ctrl
  import cnn_avgp_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int IMAGE_WIDTH     = DEF_IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT    = DEF_IMAGE_HEIGHT,
  parameter int CHANNEL_NUM_IN  = DEF_CHANNEL_NUM_IN,
  parameter int OUT_PER_CHANNEL = IMAGE_WIDTH * IMAGE_HEIGHT,
  parameter int DRAIN_TIMEOUT   = 1024,
  localparam int IMG_SIZE = IMAGE_WIDTH * IMAGE_HEIGHT,
  localparam int N_IN     = CHANNEL_NUM_IN * IMG_SIZE,
  localparam int N_OUT    = CHANNEL_NUM_IN * OUT_PER_CHANNEL,
  localparam int RD_AW    = $clog2(N_IN),
  localparam int WR_OW    = $clog2(N_OUT),
  localparam int CH_W     = idx_width(CHANNEL_NUM_IN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [CH_W-1:0]       cur_channel,
  output logic                  mem_rd_en,
  output logic [RD_AW-1:0]      mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  pool_valid_in,
  output logic [DATA_WIDTH-1:0] pool_pxl_in,
  input  logic                  pool_valid_out,
  input  logic [DATA_WIDTH-1:0] pool_pxl_out,
  output logic                  out_wr_en,
  output logic [WR_OW-1:0]      out_wr_addr,
  output logic [DATA_WIDTH-1:0] out_wr_data
);

  localparam int WR_CW = $clog2(N_OUT + 1);
  localparam int WD_W  = $clog2(DRAIN_TIMEOUT + 1);

  avgp_ctrl_state_t  state;
  logic [WD_W-1:0]   wd;
  logic [WR_CW-1:0]  wr_cnt;
  logic [CH_W-1:0]   wr_group_unused;
  logic              start_ok;
  logic              rd_last;
  logic              wr_full;
  logic              wr_room;
  logic              collect_ok;

  assign start_ok   = (state == ST_IDLE) && start;
  assign wr_room    = (wr_cnt < WR_CW'(N_OUT));
  assign collect_ok = pool_valid_out && wr_room &&
                      ((state == ST_READ) || (state == ST_DRAIN));

  cnn_frame_counter #(
    .MAX_COUNT (N_IN - 1),
    .TC_VALUE  (N_IN - 1),
    .GROUP     (IMG_SIZE),
    .GROUPS    (CHANNEL_NUM_IN)
  ) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .inc   (state == ST_READ),
    .count (mem_rd_addr),
    .group (cur_channel),
    .tc    (rd_last)
  );

  cnn_frame_counter #(
    .MAX_COUNT (N_OUT),
    .TC_VALUE  (N_OUT),
    .GROUP     (OUT_PER_CHANNEL),
    .GROUPS    (CHANNEL_NUM_IN)
  ) u_wr_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (start_ok),
    .inc   (collect_ok),
    .count (wr_cnt),
    .group (wr_group_unused),
    .tc    (wr_full)
  );

  // The memory's output register is the feed stage, so data aligns with pool_valid_in.
  assign pool_pxl_in = pool_valid_in ? mem_rd_data : '0;

  // Run FSM with registered handshake, feed-valid and collect outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      error         <= 1'b0;
      mem_rd_en     <= 1'b0;
      pool_valid_in <= 1'b0;
      out_wr_en     <= 1'b0;
      out_wr_addr   <= '0;
      out_wr_data   <= '0;
      wd            <= '0;
    end else begin
      done          <= 1'b0;
      out_wr_en     <= 1'b0;
      pool_valid_in <= mem_rd_en;
      if (collect_ok) begin
        out_wr_en   <= 1'b1;
        out_wr_addr <= wr_cnt[WR_OW-1:0];
        out_wr_data <= pool_pxl_out;
      end
      // Outputs with no run to absorb them, or beyond the frame, are flagged.
      if (pool_valid_out && ((state == ST_IDLE) || !wr_room)) begin
        error <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_READ;
            busy      <= 1'b1;
            error     <= 1'b0;
            mem_rd_en <= 1'b1;
          end
        end
        ST_READ: begin
          if (rd_last) begin
            state     <= ST_DRAIN;
            mem_rd_en <= 1'b0;
            wd        <= '0;
          end
        end
        ST_DRAIN: begin
          if (wr_full) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (wd == WD_W'(DRAIN_TIMEOUT)) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
            error <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnn_avgp_3x3_ctrl.sv
// Self-checking bench: behavioural memory and 20-cycle pool, write scoreboard, run table.
module tb_cnn_avgp_3x3_ctrl;
  import cnn_avgp_pkg::*;

  localparam int DW  = 32;
  localparam int TOT = TOTAL_IN;
  localparam int IMG = IMAGE_SIZE;
  localparam int DLY = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, error;
  logic [1:0]    cur_channel;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data = '0;
  logic          pool_valid_in;
  logic [DW-1:0] pool_pxl_in;
  logic          pool_valid_out;
  logic [DW-1:0] pool_pxl_out;
  logic          out_wr_en;
  logic [OW-1:0] out_wr_addr;
  logic [DW-1:0] out_wr_data;

  always #5 clk = ~clk;

  cnn_avgp_3x3_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .cur_channel(cur_channel), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .pool_valid_in(pool_valid_in), .pool_pxl_in(pool_pxl_in),
    .pool_valid_out(pool_valid_out), .pool_pxl_out(pool_pxl_out), .out_wr_en(out_wr_en),
    .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data)
  );

  function automatic logic [31:0] pattern(input int a);
    return 32'h5A00_0000 ^ (32'(a) * 32'h0001_0003);
  endfunction

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Synchronous-read input buffer
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= pattern(int'(mem_rd_addr));

  // Behavioural pool: fixed delay, one output per input, optional output cap
  logic          pipe_v [DLY];
  logic [DW-1:0] pipe_d [DLY];
  int            emitted;
  int            pool_limit = TOT;
  logic          pool_clear = 1'b0;
  logic          spur_v = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DLY; i++) pipe_v[i] <= 1'b0;
      emitted <= 0;
    end else begin
      pipe_v[0] <= pool_valid_in;
      pipe_d[0] <= pool_pxl_in;
      for (int i = 1; i < DLY; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
      if (pool_clear) emitted <= 0;
      else if (pipe_v[DLY-1]) emitted <= emitted + 1;
    end
  end

  assign pool_valid_out = (pipe_v[DLY-1] && (emitted < pool_limit)) || spur_v;
  assign pool_pxl_out   = spur_v ? 32'hDEAD_BEEF : pipe_d[DLY-1];

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t sb[$];

  int exp_rd_addr = 0, wr_seen = 0, done_cnt = 0, last_wr_addr = 0;
  int cyc = 0, last_rd_cyc = 0, last_wr_cyc = 0, done_cyc = 0;

  // Monitor: read-order checks, scoreboard push on reads, pop/compare on writes
  initial forever begin
    wr_t e;
    @(negedge clk);
    cyc++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (!reset) begin
      if (mem_rd_en) begin
        check("rd_addr", 64'(mem_rd_addr), 64'(exp_rd_addr));
        check("cur_channel", 64'(cur_channel), 64'(exp_rd_addr / IMG));
        sb.push_back('{exp_rd_addr, pattern(exp_rd_addr)});
        exp_rd_addr++;
        last_rd_cyc = cyc;
      end
      if (out_wr_en) begin
        check("write_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_addr", 64'(out_wr_addr), 64'(e.addr));
          check("wr_data", 64'(out_wr_data), 64'(e.data));
        end
        wr_seen++;
        last_wr_addr = int'(out_wr_addr);
        last_wr_cyc  = cyc;
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(mem_rd_addr), 64'd0);
    check({tag, "_chan"}, 64'(cur_channel), 64'd0);
    check({tag, "_pvin"}, 64'(pool_valid_in), 64'd0);
    check({tag, "_ppin"}, 64'(pool_pxl_in), 64'd0);
    check({tag, "_wr_en"}, 64'(out_wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(out_wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(out_wr_data), 64'd0);
  endtask

  typedef struct {
    int limit; int restart_at; int extra; bit start_on_done;
    bit exp_err; int exp_writes; bit gap_from_rd; int exp_gap;
  } run_t;

  // Launch a run at a negedge; clears bench-side run state first
  task automatic launch();
    sb.delete();
    exp_rd_addr = 0; wr_seen = 0; done_cnt = 0; last_wr_addr = 0;
    pool_clear = 1'b1; start = 1'b1;
    @(negedge clk);
    pool_clear = 1'b0; start = 1'b0;
    check("first_rd_en", 64'(mem_rd_en), 64'd1);
    check("busy_on", 64'(busy), 64'd1);
    check("error_cleared", 64'(error), 64'd0);
    @(negedge clk);
    check("first_pvin", 64'(pool_valid_in), 64'd1);
    check("first_ppin", 64'(pool_pxl_in), 64'(pattern(0)));
  endtask

  task automatic run_one(input run_t r);
    int  extra_left;
    bit  got;
    extra_left = r.extra;
    got = 1'b0;
    pool_limit = r.limit;
    launch();
    for (int k = 0; k < 4000 && !got; k++) begin
      start  = (r.restart_at >= 0) && mem_rd_en && (int'(mem_rd_addr) == r.restart_at);
      spur_v = (extra_left > 0) && (emitted >= TOT);
      if (spur_v) extra_left--;
      if (done) begin
        got = 1'b1;
        check("busy_low_at_done", 64'(busy), 64'd0);
        start = r.start_on_done;
      end
      @(negedge clk);
    end
    check("done_seen", 64'(got), 64'd1);
    check("no_restart_after_done", 64'(mem_rd_en), 64'd0);
    check("idle_after_done", 64'(busy), 64'd0);
    start = 1'b0;
    while (extra_left > 0) begin
      spur_v = 1'b1; extra_left--;
      @(negedge clk);
    end
    spur_v = 1'b0;
    repeat (3) @(negedge clk);
    check("done_once", 64'(done_cnt), 64'd1);
    check("run_error", 64'(error), 64'(r.exp_err));
    check("reads_total", 64'(exp_rd_addr), 64'(TOT));
    check("writes_total", 64'(wr_seen), 64'(r.exp_writes));
    check("last_wr_addr", 64'(last_wr_addr), 64'(r.exp_writes - 1));
    check("sb_leftover", 64'(sb.size()), 64'(TOT - r.exp_writes));
    check("done_timing", 64'(r.gap_from_rd ? (done_cyc - last_rd_cyc) : (done_cyc - last_wr_cyc)),
          64'(r.exp_gap));
  endtask

  run_t runs[5];

  initial begin
    bit found;
    runs[0] = '{TOT,  -1,  0, 1'b0, 1'b0, TOT,  1'b0, 1};     // nominal
    runs[1] = '{TOT,  500, 0, 1'b0, 1'b0, TOT,  1'b0, 1};     // start re-pulsed mid-run
    runs[2] = '{1000, -1,  0, 1'b0, 1'b1, 1000, 1'b1, 1026};  // stalled pool, watchdog
    runs[3] = '{TOT,  -1,  10, 1'b0, 1'b1, TOT, 1'b0, 1};     // ten extra outputs
    runs[4] = '{TOT,  -1,  0, 1'b1, 1'b0, TOT,  1'b0, 1};     // start coincident with done

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_all_zero("idle");

    for (int i = 0; i < 5; i++) run_one(runs[i]);

    // Spurious pool output while idle
    wr_seen = 0;
    spur_v = 1'b1;
    @(negedge clk);
    spur_v = 1'b0;
    check("idle_spur_error", 64'(error), 64'd1);
    check("idle_spur_no_wr", 64'(out_wr_en), 64'd0);
    @(negedge clk);
    check("idle_spur_no_wr2", 64'(wr_seen), 64'd0);

    // Reset in the middle of a run
    pool_limit = TOT;
    launch();
    found = 1'b0;
    for (int k = 0; k < 2000 && !found; k++) begin
      if (mem_rd_en && (int'(mem_rd_addr) == 300)) found = 1'b1;
      else @(negedge clk);
    end
    check("reached_rd300", 64'(found), 64'd1);
    done_cnt = 0;
    #2 reset = 1'b1;
    #1 check_all_zero("midrun_reset");
    repeat (3) @(negedge clk);
    check("no_done_on_reset", 64'(done_cnt), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    run_one(runs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
